// File: rtl/bitserial_relu_quantizer_mc.sv
// rtl/bitserial_relu_quantizer_mc.sv - multi-channel bit-serial ReLU + fixed-point window quantizer
// Optional round-half-up on bit QUANT_LSB-1 is enabled by defining ROUND_NEAREST_EN.
module bitserial_relu_quantizer_mc #(
    parameter int NUM_CH    = 4,
    parameter int WORD_LEN  = 32,
    parameter int OUT_W     = 8,
    parameter int QUANT_LSB = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    frame_start,
    input  logic [NUM_CH-1:0]       in_bits,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    output logic [NUM_CH-1:0]       out_sat,
    output logic                    frame_err
);
    localparam int CW = $clog2(WORD_LEN);
    localparam logic [CW-1:0] WIN_LO = CW'(QUANT_LSB);
    localparam logic [CW-1:0] WIN_HI = CW'(QUANT_LSB + OUT_W);
    localparam logic [CW-1:0] LAST   = CW'(WORD_LEN - 1);

    generate
        if (QUANT_LSB + OUT_W > WORD_LEN - 1) begin : g_bad_window
            $error("bitserial_relu_quantizer_mc: window overlaps the sign bit");
        end
`ifdef ROUND_NEAREST_EN
        if (QUANT_LSB < 1) begin : g_bad_round
            $error("bitserial_relu_quantizer_mc: rounding needs QUANT_LSB >= 1");
        end
`endif
    endgenerate

    logic [CW-1:0]                   cnt;
    logic [CW-1:0]                   k;
    logic [NUM_CH-1:0][OUT_W-1:0]    win;
    logic [NUM_CH-1:0]               ovf;
    logic [NUM_CH*OUT_W-1:0]         res_data;
    logic [NUM_CH-1:0]               res_sat;
`ifdef ROUND_NEAREST_EN
    localparam logic [CW-1:0] RND_BIT = CW'(QUANT_LSB - 1);
    logic [NUM_CH-1:0]               rnd;
`endif

    // A frame_start sample always restarts the word at bit 0.
    assign k = frame_start ? '0 : cnt;

    always_comb begin
        res_data = '0;
        res_sat  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (in_bits[ch]) begin
                res_data[ch*OUT_W +: OUT_W] = '0;
            end else if (ovf[ch]) begin
                res_data[ch*OUT_W +: OUT_W] = '1;
                res_sat[ch]                 = 1'b1;
`ifdef ROUND_NEAREST_EN
            end else if (rnd[ch] && (&win[ch])) begin
                res_data[ch*OUT_W +: OUT_W] = '1;
                res_sat[ch]                 = 1'b1;
            end else begin
                res_data[ch*OUT_W +: OUT_W] = win[ch] + OUT_W'(rnd[ch]);
`else
            end else begin
                res_data[ch*OUT_W +: OUT_W] = win[ch];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            win       <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            frame_err <= 1'b0;
`ifdef ROUND_NEAREST_EN
            rnd       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            frame_err <= in_valid && frame_start && (cnt != '0);
            if (in_valid) begin
                cnt <= (k == LAST) ? '0 : k + 1'b1;
                if (k == LAST) begin
                    out_valid <= 1'b1;
                    out_data  <= res_data;
                    out_sat   <= res_sat;
                    win       <= '0;
                    ovf       <= '0;
`ifdef ROUND_NEAREST_EN
                    rnd       <= '0;
`endif
                end else begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        // LSB-first arrival: shifting in at the top leaves bit QUANT_LSB at bit 0.
                        if (k >= WIN_LO && k < WIN_HI)
                            win[ch] <= (win[ch] >> 1) | (OUT_W'(in_bits[ch]) << (OUT_W - 1));
                        else if (k == '0)
                            win[ch] <= '0;
                        if (k >= WIN_HI)
                            ovf[ch] <= ovf[ch] | in_bits[ch];
                        else if (k == '0)
                            ovf[ch] <= 1'b0;
`ifdef ROUND_NEAREST_EN
                        if (k == RND_BIT)
                            rnd[ch] <= in_bits[ch];
                        else if (k == '0)
                            rnd[ch] <= 1'b0;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bitserial_relu_quantizer_mc.sv
// tb/tb_bitserial_relu_quantizer_mc.sv - scoreboard bench for bitserial_relu_quantizer_mc
module tb_bitserial_relu_quantizer_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        frame_start;
    logic [3:0]  in_bits;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_sat;
    logic        frame_err;

    bitserial_relu_quantizer_mc dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .frame_start(frame_start),
        .in_bits(in_bits), .out_valid(out_valid), .out_data(out_data),
        .out_sat(out_sat), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  sat;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ferr_q[$];
    int   cyc = 0;
    int   pos = 0;
    int   passed = 0;
    int   total = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_sat", {28'd0, out_sat}, {28'd0, e.sat});
                check("out_valid_cycle", cyc, e.cyc);
            end
        end
        if (frame_err) begin
            if (ferr_q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
            else check("frame_err_cycle", cyc, ferr_q.pop_front());
        end
    end

    function automatic void model(input logic [3:0][31:0] w,
                                  output logic [31:0] d, output logic [3:0] s);
        d = '0;
        s = '0;
        for (int ch = 0; ch < 4; ch++) begin
            logic [7:0] win;
            win = w[ch][18:11];
            if (w[ch][31]) begin
                d[ch*8 +: 8] = 8'h00;
            end else if (|w[ch][30:19]) begin
                d[ch*8 +: 8] = 8'hFF;
                s[ch] = 1'b1;
            end else begin
`ifdef ROUND_NEAREST_EN
                if (w[ch][10] && win == 8'hFF) begin
                    d[ch*8 +: 8] = 8'hFF;
                    s[ch] = 1'b1;
                end else begin
                    d[ch*8 +: 8] = win + {7'd0, w[ch][10]};
                end
`else
                d[ch*8 +: 8] = win;
`endif
            end
        end
    endfunction

    // Drives nbits of a word from bit 0; gap is the percentage chance of an idle cycle per bit.
    task automatic drive_bits(input logic [3:0][31:0] w, input int nbits, input int gap,
                              input logic [31:0] ed, input logic [3:0] es);
        for (int b = 0; b < nbits; b++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                in_valid    = 1'b0;
                frame_start = 1'($urandom_range(1));
                in_bits     = 4'($urandom);
                @(negedge clk);
            end
            in_valid    = 1'b1;
            frame_start = (b == 0);
            for (int ch = 0; ch < 4; ch++) in_bits[ch] = w[ch][b];
            if (b == 0 && pos != 0) ferr_q.push_back(cyc + 1);
            if (b == 31) exp_q.push_back('{data: ed, sat: es, cyc: cyc + 1});
            pos = (b == 31) ? 0 : b + 1;
            @(negedge clk);
        end
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0][31:0] w;
        logic [31:0] ed;
        logic [3:0]  es;
        reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0; in_bits = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_sat", {28'd0, out_sat}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1 and 2 streamed back to back.
        w = {32'h0007F800, 32'h0, 32'h00000A00, 32'h00000C00};
`ifdef ROUND_NEAREST_EN
        drive_bits(w, 32, 0, 32'hFF000102, 4'b0000);
`else
        drive_bits(w, 32, 0, 32'hFF000101, 4'b0000);
`endif
        w = {32'h0, 32'h0, 32'h80000000, 32'hFFFFFB00};
        drive_bits(w, 32, 0, 32'h00000000, 4'b0000);

        // Test 3: overflow saturation, plus rounding carry into saturation on ch2.
        w = {32'h0, 32'h0007FC00, 32'h7FFFFFFF, 32'h00080000};
`ifdef ROUND_NEAREST_EN
        drive_bits(w, 32, 0, 32'h00FFFFFF, 4'b0111);
`else
        drive_bits(w, 32, 0, 32'h00FFFFFF, 4'b0011);
`endif

        // Test 4: frame_start at bit 5 aborts the first word.
        w = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        drive_bits(w, 5, 0, 32'h0, 4'h0);
        w = {32'h00001800, 32'h80001000, 32'h00041000, 32'h00000800};
        drive_bits(w, 32, 20, 32'h03008201, 4'b0000);
        repeat (2) @(negedge clk);

        // Test 6: reset in the middle of a word.
        w = {32'h00012800, 32'h00012800, 32'h00012800, 32'h00012800};
        drive_bits(w, 20, 0, 32'h0, 4'h0);
        reset = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("mid_reset_out_data", out_data, 32'd0);
        check("mid_reset_out_sat", {28'd0, out_sat}, 32'd0);
        @(negedge clk);
        check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        pos = 0;
        @(negedge clk);
        drive_bits(w, 32, 0, 32'h25252525, 4'b0000);

        // Test 5: random words with idle gaps, checked against the word-level model.
        for (int n = 0; n < 100; n++) begin
            for (int ch = 0; ch < 4; ch++) begin
                case ($urandom_range(3))
                    0: w[ch] = $urandom;
                    1: w[ch] = $urandom & 32'h0007FFFF;
                    2: w[ch] = ($urandom & 32'h000FFFFF) | 32'h0007FC00;
                    default: w[ch] = $urandom & 32'h7FFFFFFF;
                endcase
            end
            model(w, ed, es);
            drive_bits(w, 32, 30, ed, es);
        end

        repeat (4) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("frame_err_queue_drained", ferr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
